// File: rtl/voice_operator_scheduler_pkg.sv
// Shared types for the voice-operator scheduler: slot ID encoding, config entry layout, FSM states.
`ifndef NUM_VOICE_OPERATORS
`define NUM_VOICE_OPERATORS 256
`endif

package voice_operator_scheduler_pkg;
  localparam int VOICE_W = 5;
  localparam int OP_W    = 3;

  // Slot ID is {voice, op}; the voice field sits in the upper bits.
  typedef logic [VOICE_W+OP_W-1:0] VoiceOperatorID_t;

  localparam logic [3:0] CFG_REG_ALGORITHM = 4'd0;
  localparam logic [3:0] CFG_REG_NOTE_ON   = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } sched_state_t;

  typedef struct packed {
    VoiceOperatorID_t addr;
    logic [3:0]       reg_sel;
    logic [15:0]      data;
  } cfg_entry_t;

  function automatic VoiceOperatorID_t makeVoiceOperatorID(input logic [VOICE_W-1:0] voice,
                                                           input logic [OP_W-1:0] op);
    return {voice, op};
  endfunction

  function automatic logic [VOICE_W-1:0] getVoiceID(input VoiceOperatorID_t id);
    return id[OP_W +: VOICE_W];
  endfunction
endpackage

// File: rtl/voice_operator_scheduler_if.sv
// Scheduler control, issue and host-config signals; master = scheduler, slave = its environment.
interface voice_operator_scheduler_if
  import voice_operator_scheduler_pkg::*;
#(
  parameter int NUM_CFG_REGS = 8
);
  logic                    i_Enable;
  logic                    i_SampleTick;
  logic                    o_IssueValid;
  VoiceOperatorID_t        o_VoiceOperator;
  logic                    o_NoteOn;
  logic                    o_FrameDone;
  logic                    o_Busy;
  logic                    i_CfgValid;
  logic                    o_CfgReady;
  VoiceOperatorID_t        i_CfgAddr;
  logic [3:0]              i_CfgReg;
  logic [15:0]             i_CfgData;
  VoiceOperatorID_t        o_ConfigWriteAddr;
  logic [15:0]             o_ConfigWriteData;
  logic [NUM_CFG_REGS-1:0] o_RegWriteEnable;
`ifdef SCHEDULER_OVERRUN_COUNT_EN
  logic [15:0]             o_OverrunCount;
`endif

  modport master (
    input  i_Enable, i_SampleTick, i_CfgValid, i_CfgAddr, i_CfgReg, i_CfgData,
    output o_IssueValid, o_VoiceOperator, o_NoteOn, o_FrameDone, o_Busy, o_CfgReady,
           o_ConfigWriteAddr, o_ConfigWriteData, o_RegWriteEnable
`ifdef SCHEDULER_OVERRUN_COUNT_EN
    , output o_OverrunCount
`endif
  );

  modport slave (
    output i_Enable, i_SampleTick, i_CfgValid, i_CfgAddr, i_CfgReg, i_CfgData,
    input  o_IssueValid, o_VoiceOperator, o_NoteOn, o_FrameDone, o_Busy, o_CfgReady,
           o_ConfigWriteAddr, o_ConfigWriteData, o_RegWriteEnable
`ifdef SCHEDULER_OVERRUN_COUNT_EN
    , input o_OverrunCount
`endif
  );
endinterface

// File: rtl/voice_operator_scheduler_config_write_fifo.sv
// Synchronous FIFO with registered full/empty flags; data appears at pop_data while not empty.
module config_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
      full    <= (count_d == CW'(DEPTH));
      empty   <= (count_d == '0);
    end
  end
endmodule

// File: rtl/voice_operator_scheduler.sv
// Frame sequencer: a tick in WAIT issues all voice/operator slots operator-major, one per cycle, from
// the next cycle. Host config writes queue in a FIFO drained only between frames. SCHEDULER_OVERRUN_COUNT_EN adds o_OverrunCount.
module voice_operator_scheduler
  import voice_operator_scheduler_pkg::*;
#(
  parameter int NUM_VOICES     = 32,
  parameter int NUM_OPERATORS  = 8,
  parameter int CFG_FIFO_DEPTH = 4,
  parameter int NUM_CFG_REGS   = 8
) (
  input logic                        i_Clock,
  input logic                        i_Reset,
  voice_operator_scheduler_if.master bus
);
  sched_state_t            state_q;
  sched_state_t            state_d;
  logic [VOICE_W-1:0]      voice_q;
  logic [VOICE_W-1:0]      next_voice;
  logic [OP_W-1:0]         op_q;
  logic [NUM_VOICES-1:0]   note_on_q;
  logic                    note_q;
  logic                    frame_done_q;
  logic [NUM_CFG_REGS-1:0] reg_we_q;
  VoiceOperatorID_t        cfg_addr_q;
  logic [15:0]             cfg_data_q;
  logic                    last_voice;
  logic                    last_slot;
  logic                    tick_taken;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  cfg_entry_t              push_entry;
  cfg_entry_t              head;

  always_comb begin
    push_entry         = '0;
    push_entry.addr    = bus.i_CfgAddr;
    push_entry.reg_sel = bus.i_CfgReg;
    push_entry.data    = bus.i_CfgData;
  end

  config_write_fifo #(
    .DEPTH (CFG_FIFO_DEPTH),
    .WIDTH ($bits(cfg_entry_t))
  ) u_config_write_fifo (
    .clk       (i_Clock),
    .rst       (i_Reset),
    .push      (bus.i_CfgValid && !fifo_full),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    tick_taken = 1'b0;
    last_voice = (voice_q == VOICE_W'(NUM_VOICES - 1));
    last_slot  = last_voice && (op_q == OP_W'(NUM_OPERATORS - 1));
    next_voice = last_voice ? '0 : voice_q + 1'b1;
    case (state_q)
      S_IDLE: if (bus.i_Enable) state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.i_Enable) begin
          state_d = S_IDLE;
        end else if (bus.i_SampleTick) begin
          state_d    = S_RUN;
          tick_taken = 1'b1;
        end
      end
      // Ticks here, including the final-slot cycle, never restart the frame.
      S_RUN:   if (last_slot) state_d = bus.i_Enable ? S_WAIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A taken tick wins over draining; the head entry waits for the next gap.
    pop = (state_q != S_RUN) && !fifo_empty && !tick_taken;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= S_IDLE;
      voice_q      <= '0;
      op_q         <= '0;
      note_on_q    <= '0;
      note_q       <= 1'b0;
      frame_done_q <= 1'b0;
      reg_we_q     <= '0;
      cfg_addr_q   <= '0;
      cfg_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= (state_q == S_RUN) && last_slot;
      reg_we_q     <= '0;
      if (tick_taken) begin
        voice_q <= '0;
        op_q    <= '0;
        note_q  <= note_on_q[0];
      end else if ((state_q == S_RUN) && !last_slot) begin
        voice_q <= next_voice;
        if (last_voice) op_q <= op_q + 1'b1;
        note_q  <= note_on_q[next_voice];
      end
      // Pops only occur between frames, so note-on bits never change mid-frame.
      if (pop) begin
        if (head.reg_sel == CFG_REG_NOTE_ON) begin
          note_on_q[getVoiceID(head.addr)] <= head.data[0];
        end else if (32'(head.reg_sel) < NUM_CFG_REGS) begin
          reg_we_q   <= NUM_CFG_REGS'(1) << head.reg_sel;
          cfg_addr_q <= head.addr;
          cfg_data_q <= head.data;
        end
      end
    end
  end

`ifdef SCHEDULER_OVERRUN_COUNT_EN
  logic [15:0] overrun_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      overrun_q <= '0;
    end else if ((state_q == S_RUN) && bus.i_SampleTick && (overrun_q != 16'hFFFF)) begin
      overrun_q <= overrun_q + 1'b1;
    end
  end

  assign bus.o_OverrunCount = overrun_q;
`endif

  assign bus.o_IssueValid      = (state_q == S_RUN);
  assign bus.o_Busy            = (state_q == S_RUN);
  assign bus.o_VoiceOperator   = makeVoiceOperatorID(voice_q, op_q);
  assign bus.o_NoteOn          = note_q;
  assign bus.o_FrameDone       = frame_done_q;
  assign bus.o_CfgReady        = !fifo_full;
  assign bus.o_ConfigWriteAddr = cfg_addr_q;
  assign bus.o_ConfigWriteData = cfg_data_q;
  assign bus.o_RegWriteEnable  = reg_we_q;
endmodule
